piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in serial-out transmitter; the companion of the team's serial-in right-shift register (receiver).
- Accepts N-bit words through a valid/ready handshake and emits them LSB-first on SOUT, with SEN qualifying each bit.
- SOUT/SEN wire directly to the receiver's in/EN. After N qualified edges, the receiver's Q equals the transmitted word.
- One-word holding buffer allows gapless back-to-back words.

Parameters:
N, 4, word width in bits (N >= 2)
CW, $clog2(N), bit-counter width

Ports:
CLK  input  1  clock; all state updates on posedge
RST  input  1  asynchronous reset, active-high
LOAD_VALID  input  1  DIN holds a word to transmit
LOAD_READY  output  1  block can accept a word this cycle
DIN  input  N  parallel word
SOUT  output  1  serial data, LSB first; equals shreg[0]
SEN  output  1  high while SOUT carries a valid bit; drives receiver EN
DONE  output  1  high during the cycle carrying the last bit (bit N-1) of a word

Behaviour:
- Interface: one clock (CLK); reset RST is asynchronous and active-high.
- Reset, asynchronous on RST high:
  - state=IDLE, shreg=0, count=0, hold_valid=0.
  - Outputs: SOUT=0, SEN=0, DONE=0, LOAD_READY=1.
- Handshake: a word is accepted at a posedge where LOAD_VALID && LOAD_READY. LOAD_READY = !hold_valid; it is a registered-state function and never depends on LOAD_VALID.
- States: IDLE, SHIFT. Output decode: SEN = (state==SHIFT); DONE = SEN && count==N-1.
- IDLE:
  - On accept: shreg<=DIN, count<=0, state<=SHIFT.
  - Latency: bit 0 appears on SOUT with SEN=1 in the cycle after acceptance.
- SHIFT, count < N-1:
  - shreg<=shreg>>1 (MSB filled 0), count<=count+1.
  - Any accept writes DIN into hold, hold_valid<=1.
- SHIFT, count == N-1 (last-bit edge):
  - If hold_valid: shreg<=hold, hold_valid<=0, count<=0, stay SHIFT.
  - Else if accept this edge: shreg<=DIN (bypass), count<=0, stay SHIFT.
  - Else: state<=IDLE, count<=0.
  - No idle cycle between consecutive words when the next word is present by the last-bit edge.
- Hold full:
  - LOAD_READY=0; LOAD_VALID is ignored and DIN is not sampled.
  - Hold drains on the last-bit edge, and LOAD_READY returns to 1 the following cycle.
- Simultaneous events: an accept on the last-bit edge while hold_valid=1 is impossible, because LOAD_READY=0.
- Counter: count wraps only via explicit reset to 0, never via overflow. For non-power-of-2 N, count never exceeds N-1.
- Reset mid-word:
  - The word in flight and the held word are discarded; SEN drops immediately (asynchronous).
  - No partial-word DONE is generated.
- IDLE: SOUT=shreg[0]. shreg is 0 after a completed word (it has been fully shifted out).
- Throughput: exactly N SEN-high cycles per accepted word; DONE high exactly once per word.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, SHIFT=1'b1) and the default width constant N=4, reused by the receiver bench.
- One natural sub-module: bit_counter. Inputs are CLK, RST, clear and inc; outputs are count and last (count==N-1). The FSM, shreg and hold stay in piso_serializer.

Test Plan:
- Single word: N=4, DIN=4'b1010 accepted at t0, with the receiver shiftreg attached (SOUT->in, SEN->EN). Required: SOUT=0,1,0,1 on cycles t0+1..t0+4; SEN=1 for exactly those 4 cycles; DONE only at t0+4; receiver Q=1010 afterward; SEN=0 at t0+5.
- Back-to-back: 4'b0011 then 4'b1100, with LOAD_VALID held. Required: 8 consecutive SEN-high cycles, SOUT=1,1,0,0,0,0,1,1. LOAD_READY=0 from after the second accept until the last-bit edge of word 1.
- Bypass: second word 4'b0110 presented first on word 1's last-bit edge. Required: accepted there; next cycle SOUT=0 (bit 0 of 0110) with SEN=1; no gap.
- Backpressure: three words offered continuously. Required: third not accepted (LOAD_READY=0) until hold drains; no word lost or duplicated; 12 SEN cycles; DONE pulses exactly 3.
- Reset mid-word: RST asserted after 2 bits of 4'b1111, with hold full. Required: SEN, DONE and SOUT=0 immediately; LOAD_READY=1; after release, no further SEN until a new accept.
- Idle: LOAD_VALID=0 for 10 cycles after reset. Required: SEN=0, DONE=0, LOAD_READY=1 throughout.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the PISO serializer and its receiver-side benches.
// Holds the FSM state encoding and the default word width.
package piso_serializer_pkg;

  // Default word width, shared with the receiver bench.
  localparam int N_DEF = 4;

  // Transmitter states: IDLE waits for a word, SHIFT emits one bit per cycle.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage : piso_serializer_pkg

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle of the PISO serializer.
// The master offers parallel words and observes the serial stream.
// The slave (the serializer) accepts words and drives the stream.
interface piso_serializer_if #(
  parameter int N = 4
) ();

  logic         LOAD_VALID;  // DIN holds a word to transmit
  logic         LOAD_READY;  // serializer can take a word this cycle
  logic [N-1:0] DIN;         // parallel word
  logic         SOUT;        // serial data, LSB first
  logic         SEN;         // SOUT carries a valid bit
  logic         DONE;        // SOUT carries the last bit of a word

  modport master (
    output LOAD_VALID,
    output DIN,
    input  LOAD_READY,
    input  SOUT,
    input  SEN,
    input  DONE
  );

  modport slave (
    input  LOAD_VALID,
    input  DIN,
    output LOAD_READY,
    output SOUT,
    output SEN,
    output DONE
  );

endinterface : piso_serializer_if

// File: rtl/piso_serializer_bit_counter.sv
// Bit position counter for the serializer.
// Counts the bit currently on SOUT; 'last' flags bit N-1.
// The counter only returns to 0 through 'clear', never by overflow,
// so for non-power-of-2 N it never exceeds N-1.
module piso_serializer_bit_counter
  import piso_serializer_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          last
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins over increment, otherwise hold.
  always_comb begin
    // NOTE: assign a default first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CW'(N - 1));

  // The count must never run past the last bit position.
  a_count_in_range : assert property (
    @(posedge CLK) disable iff (RST) count_q <= CW'(N - 1)
  );

endmodule : piso_serializer_bit_counter

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter.
// Accepts N-bit words over LOAD_VALID/LOAD_READY and emits them LSB first
// on SOUT with SEN qualifying each bit. A one-word holding buffer lets the
// next word follow the current one with no idle cycle in between.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = $clog2(N)
) (
  input  logic               CLK,
  input  logic               RST,
  piso_serializer_if.slave   bus
);

  state_e        state_q;
  logic [N-1:0]  shreg_q;
  logic [N-1:0]  hold_q;
  logic          hold_valid_q;

  logic [CW-1:0] count;
  logic          last;
  logic          accept;
  logic          cnt_clear;
  logic          cnt_inc;
  logic          sen;

  // Ready depends only on registered state, never on LOAD_VALID.
  assign accept = bus.LOAD_VALID && !hold_valid_q;

  // Counter restarts whenever a word (re)starts or the engine is idle.
  assign cnt_clear = (state_q == IDLE) || last;
  assign cnt_inc   = (state_q == SHIFT) && !last;

  piso_serializer_bit_counter #(
    .N  (N),
    .CW (CW)
  ) u_bit_counter (
    .CLK   (CLK),
    .RST   (RST),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (count),
    .last  (last)
  );

  // Transmit FSM with shift register and holding buffer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_q <= bus.DIN;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (!last) begin
            shreg_q <= shreg_q >> 1;
            if (accept) begin
              hold_q       <= bus.DIN;
              hold_valid_q <= 1'b1;
            end
          end else if (hold_valid_q) begin
            // Held word follows immediately; hold frees up next cycle.
            shreg_q      <= hold_q;
            hold_valid_q <= 1'b0;
          end else if (accept) begin
            // Word arriving on the last-bit edge bypasses the hold.
            shreg_q <= bus.DIN;
          end else begin
            // Final shift leaves shreg at 0 while idle.
            shreg_q <= shreg_q >> 1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sen            = (state_q == SHIFT);
  assign bus.SEN        = sen;
  assign bus.SOUT       = shreg_q[0];
  assign bus.DONE       = sen && last;
  assign bus.LOAD_READY = !hold_valid_q;

  // A word offered on the last-bit edge while the hold is full cannot be accepted.
  a_no_accept_when_full : assert property (
    @(posedge CLK) disable iff (RST) (sen && last && hold_valid_q) |-> !accept
  );

  // DONE is only ever raised while a bit is being transmitted.
  a_done_implies_sen : assert property (
    @(posedge CLK) disable iff (RST) bus.DONE |-> bus.SEN
  );

  // The bit counter reports its position; only 'last' is needed here.
  logic unused_count;
  assign unused_count = ^count;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer.
// Accepted words push their bits onto an expected-bit queue; every cycle the
// serial outputs are compared with the queue head. A receiver shift register
// (SOUT -> in, SEN -> EN) rebuilds each word for an end-to-end check.
module tb_piso_serializer;
  import piso_serializer_pkg::*;

  localparam int N = N_DEF;

  typedef struct packed {
    logic [N-1:0] word;
    logic         b;
    logic         last;
  } exp_bit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  piso_serializer_if #(.N(N)) bus ();

  piso_serializer #(.N(N)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Receiver model: right shift register, serial input enters at the MSB.
  logic [N-1:0] rx_q = '0;
  always @(posedge clk) begin
    if (bus.SEN === 1'b1) rx_q <= {bus.SOUT, rx_q[N-1:1]};
  end

  exp_bit_t     exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           sen_cnt  = 0;
  int           done_cnt = 0;
  logic         pending  = 1'b0;
  logic [N-1:0] pend_word = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance past the edge, compare outputs.
  task automatic tick(input logic v, input logic [N-1:0] d, output logic acc);
    exp_bit_t e;
    acc = v && (bus.LOAD_READY === 1'b1);
    bus.LOAD_VALID = v;
    bus.DIN        = d;
    if (acc) begin
      for (int i = 0; i < N; i++) exp_q.push_back('{word: d, b: d[i], last: (i == N - 1)});
    end
    @(posedge clk);
    #1;
    if (pending) begin
      check("rx_word", 32'(rx_q), 32'(pend_word));
      pending = 1'b0;
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sen", 32'(bus.SEN), 32'd1);
      check("sout", 32'(bus.SOUT), 32'(e.b));
      check("done", 32'(bus.DONE), 32'(e.last));
      if (e.last) begin
        pending   = 1'b1;
        pend_word = e.word;
      end
    end else begin
      check("sen_idle", 32'(bus.SEN), 32'd0);
      check("sout_idle", 32'(bus.SOUT), 32'd0);
      check("done_idle", 32'(bus.DONE), 32'd0);
    end
    // Hold is full exactly when a whole word waits behind the current one.
    check("ready", 32'(bus.LOAD_READY), 32'(exp_q.size() < N));
    if (bus.SEN === 1'b1) sen_cnt++;
    if (bus.DONE === 1'b1) done_cnt++;
  endtask

  task automatic drain();
    logic acc;
    for (int k = 0; k < 40 && (exp_q.size() > 0 || pending); k++) tick(1'b0, '0, acc);
    check("drain_timeout", 32'(exp_q.size() == 0 && !pending), 32'd1);
  endtask

  initial begin
    logic         acc;
    logic [N-1:0] words [3];
    int           idx;

    bus.LOAD_VALID = 1'b0;
    bus.DIN        = '0;

    // Reset state.
    #12;
    check("rst_sout", 32'(bus.SOUT), 32'd0);
    check("rst_sen", 32'(bus.SEN), 32'd0);
    check("rst_done", 32'(bus.DONE), 32'd0);
    check("rst_ready", 32'(bus.LOAD_READY), 32'd1);
    #10;
    rst = 1'b0;

    // Idle for 10 cycles.
    for (int k = 0; k < 10; k++) tick(1'b0, '0, acc);

    // Single word.
    sen_cnt = 0; done_cnt = 0;
    tick(1'b1, 4'b1010, acc);
    check("single_acc", 32'(acc), 32'd1);
    drain();
    check("single_rx", 32'(rx_q), 32'b1010);
    check("single_sen_cnt", sen_cnt, 4);
    check("single_done_cnt", done_cnt, 1);

    // Back-to-back with LOAD_VALID held.
    sen_cnt = 0; done_cnt = 0;
    tick(1'b1, 4'b0011, acc);
    check("b2b_acc1", 32'(acc), 32'd1);
    tick(1'b1, 4'b1100, acc);
    check("b2b_acc2", 32'(acc), 32'd1);
    drain();
    check("b2b_sen_cnt", sen_cnt, 8);
    check("b2b_done_cnt", done_cnt, 2);

    // Bypass: second word first offered on the last-bit edge.
    sen_cnt = 0; done_cnt = 0;
    tick(1'b1, 4'b1001, acc);
    for (int k = 0; k < 3; k++) tick(1'b0, '0, acc);
    tick(1'b1, 4'b0110, acc);
    check("bypass_acc", 32'(acc), 32'd1);
    drain();
    check("bypass_sen_cnt", sen_cnt, 8);

    // Backpressure: three words offered continuously.
    sen_cnt = 0; done_cnt = 0;
    words[0] = 4'b1001; words[1] = 4'b0111; words[2] = 4'b1110;
    idx = 0;
    for (int k = 0; k < 40 && idx < 3; k++) begin
      tick(1'b1, words[idx], acc);
      if (acc) idx++;
    end
    check("bp_all_sent", idx, 3);
    drain();
    check("bp_sen_cnt", sen_cnt, 12);
    check("bp_done_cnt", done_cnt, 3);

    // Reset mid-word with the hold full.
    tick(1'b1, 4'b1111, acc);
    tick(1'b1, 4'b0101, acc);
    check("mid_hold_acc", 32'(acc), 32'd1);
    check("mid_hold_full", 32'(bus.LOAD_READY), 32'd0);
    bus.LOAD_VALID = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    pending = 1'b0;
    check("mid_rst_sen", 32'(bus.SEN), 32'd0);
    check("mid_rst_done", 32'(bus.DONE), 32'd0);
    check("mid_rst_sout", 32'(bus.SOUT), 32'd0);
    check("mid_rst_ready", 32'(bus.LOAD_READY), 32'd1);
    sen_cnt = 0; done_cnt = 0;
    tick(1'b0, '0, acc);
    tick(1'b0, '0, acc);
    #3;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) tick(1'b0, '0, acc);
    check("post_rst_sen_cnt", sen_cnt, 0);
    check("post_rst_done_cnt", done_cnt, 0);

    // New word after reset transmits normally.
    tick(1'b1, 4'b0100, acc);
    drain();
    check("post_rst_rx", 32'(rx_q), 32'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_piso_serializer
